// File: rtl/operand_fetch_sb_if.sv
// Decode / register-file / write-back / execute bus of the operand fetch stage.
// master: the surrounding pipeline (decode, register file, write-back, execute).
// slave:  operand_fetch_sb.
interface operand_fetch_sb_if #(
  parameter int XLEN = 32
);
  // decode side
  logic            id_valid;
  logic            id_ready;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [4:0]      id_rd_addr;
  logic            id_rd_we;
  // register-file read ports
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  // write-back
  logic            wb_valid;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;
  // execute side
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_we;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_we, rf_rs1_data, rf_rs2_data,
           wb_valid, wb_rd_addr, wb_rd_data, ex_ready,
    input  id_ready, rf_rs1_addr, rf_rs2_addr,
           ex_valid, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_rd_we
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_we, rf_rs1_data, rf_rs2_data,
           wb_valid, wb_rd_addr, wb_rd_data, ex_ready,
    output id_ready, rf_rs1_addr, rf_rs2_addr,
           ex_valid, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_rd_we
  );
endinterface

// File: rtl/operand_fetch_sb.sv
// Operand fetch with busy-bit scoreboard: reads rs1/rs2, bypasses same-cycle write-back,
// and stalls decode on RAW/WAW hazards; one registered stage to execute (1-cycle latency).
// Backpressure: id_ready drops when the execute slot is full, on any hazard, or on flush.
// Ports: clk, rst_n (async active-low), flush (sync kill), bus (slave side of
// operand_fetch_sb_if: decode, register-file read, write-back, execute), stall_cnt
// (saturating count of hazard-stall cycles).
module operand_fetch_sb #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  operand_fetch_sb_if.slave   bus,
  output logic [31:0]         stall_cnt
);

  // busy[0] is never set, so x0 can never stall anything.
  logic [31:0]     busy;
  logic [31:0]     busy_nxt;

  logic            rs1_wb_hit;
  logic            rs2_wb_hit;
  logic            rd_wb_hit;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            waw_hazard;
  logic            slot_free;
  logic            issue;
  logic            stall_cyc;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;

  assign bus.rf_rs1_addr = bus.id_rs1_addr;
  assign bus.rf_rs2_addr = bus.id_rs2_addr;

  assign rs1_wb_hit = bus.wb_valid && (bus.wb_rd_addr == bus.id_rs1_addr) && (bus.id_rs1_addr != 5'd0);
  assign rs2_wb_hit = bus.wb_valid && (bus.wb_rd_addr == bus.id_rs2_addr) && (bus.id_rs2_addr != 5'd0);
  assign rd_wb_hit  = bus.wb_valid && (bus.wb_rd_addr == bus.id_rd_addr)  && (bus.id_rd_addr  != 5'd0);

  // A write-back landing this cycle resolves the hazard: the value is bypassed below.
  assign rs1_hazard = bus.id_rs1_used && (bus.id_rs1_addr != 5'd0) && busy[bus.id_rs1_addr] && !rs1_wb_hit;
  assign rs2_hazard = bus.id_rs2_used && (bus.id_rs2_addr != 5'd0) && busy[bus.id_rs2_addr] && !rs2_wb_hit;
  assign waw_hazard = bus.id_rd_we    && (bus.id_rd_addr  != 5'd0) && busy[bus.id_rd_addr]  && !rd_wb_hit;

  assign slot_free    = !bus.ex_valid || bus.ex_ready;
  assign bus.id_ready = slot_free && !rs1_hazard && !rs2_hazard && !waw_hazard && !flush;
  assign issue        = bus.id_valid && bus.id_ready;
  // Only hazard stalls are counted; a full execute slot is ordinary backpressure.
  assign stall_cyc    = bus.id_valid && slot_free && !flush && !bus.id_ready;

  always_comb begin
    rs1_sel = bus.rf_rs1_data;
    if (bus.id_rs1_addr == 5'd0) rs1_sel = '0;
    else if (rs1_wb_hit)         rs1_sel = bus.wb_rd_data;
  end

  always_comb begin
    rs2_sel = bus.rf_rs2_data;
    if (bus.id_rs2_addr == 5'd0) rs2_sel = '0;
    else if (rs2_wb_hit)         rs2_sel = bus.wb_rd_data;
  end

  // Clear first, then set, so a new producer keeps ownership over a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_valid && (bus.wb_rd_addr != 5'd0))
      busy_nxt[bus.wb_rd_addr] = 1'b0;
    if (issue && bus.id_rd_we && (bus.id_rd_addr != 5'd0))
      busy_nxt[bus.id_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_rs1_data <= '0;
      bus.ex_rs2_data <= '0;
      bus.ex_rd_addr  <= 5'd0;
      bus.ex_rd_we    <= 1'b0;
    end else if (flush) begin
      bus.ex_valid    <= 1'b0;
    end else if (issue) begin
      bus.ex_valid    <= 1'b1;
      bus.ex_rs1_data <= rs1_sel;
      bus.ex_rs2_data <= rs2_sel;
      bus.ex_rd_addr  <= bus.id_rd_addr;
      bus.ex_rd_we    <= bus.id_rd_we;
    end else if (bus.ex_valid && bus.ex_ready) begin
      bus.ex_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cyc && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch_sb.sv
// Directed bench for operand_fetch_sb: hazards, bypass, x0, backpressure, WAW, flush, async reset.
module tb_operand_fetch_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] stall_cnt;
  int          checks = 0;
  int          failures = 0;

  operand_fetch_sb_if #(.XLEN(32)) bus ();

  operand_fetch_sb #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic vld, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we);
    bus.id_valid    = vld;
    bus.id_rs1_addr = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2_addr = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd_addr  = rd;
    bus.id_rd_we    = we;
  endtask

  task automatic drive_wb(input logic vld, input logic [4:0] rd, input logic [31:0] dat);
    bus.wb_valid   = vld;
    bus.wb_rd_addr = rd;
    bus.wb_rd_data = dat;
  endtask

  initial begin
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_wb(1'b0, 5'd0, 32'd0);
    bus.rf_rs1_data = 32'd0;
    bus.rf_rs2_data = 32'd0;
    bus.ex_ready    = 1'b1;
    #12;
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ex_rs1",   bus.ex_rs1_data, 32'd0);
    chk("rst_ex_rd",    {27'd0, bus.ex_rd_addr}, 32'd0);
    chk("rst_busy",     dut.busy, 32'd0);
    chk("rst_stall",    stall_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD x3 = x1 + x2 with register-file data 5 / 7
    drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
    bus.rf_rs1_data = 32'd5;
    bus.rf_rs2_data = 32'd7;
    #1;
    chk("add_id_ready", {31'd0, bus.id_ready}, 32'd1);
    chk("add_rf_addr",  {27'd0, bus.rf_rs1_addr}, 32'd1);
    tick();
    chk("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_ex_rs1",   bus.ex_rs1_data, 32'd5);
    chk("add_ex_rs2",   bus.ex_rs2_data, 32'd7);
    chk("add_ex_rd",    {27'd0, bus.ex_rd_addr}, 32'd3);
    chk("add_busy3",    {31'd0, dut.busy[3]}, 32'd1);
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_wb(1'b1, 5'd3, 32'd12);
    tick();
    chk("wb_busy3",     {31'd0, dut.busy[3]}, 32'd0);
    chk("wb_ex_drain",  {31'd0, bus.ex_valid}, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);

    // RAW: producer of x5, then a reader of x5 stalled until write-back bypass
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    chk("raw_busy5", {31'd0, dut.busy[5]}, 32'd1);
    drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    bus.rf_rs1_data = 32'h1111_1111;
    #1;
    chk("raw_stall_rdy0", {31'd0, bus.id_ready}, 32'd0);
    tick();
    chk("raw_stall_cnt1", stall_cnt, 32'd1);
    chk("raw_stall_rdy1", {31'd0, bus.id_ready}, 32'd0);
    tick();
    chk("raw_stall_cnt2", stall_cnt, 32'd2);
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("raw_bypass_rdy", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("raw_bypass_dat", bus.ex_rs1_data, 32'hDEAD_BEEF);
    chk("raw_ex_rd",      {27'd0, bus.ex_rd_addr}, 32'd6);
    chk("raw_busy5_clr",  {31'd0, dut.busy[5]}, 32'd0);
    chk("raw_busy6_set",  {31'd0, dut.busy[6]}, 32'd1);
    chk("raw_stall_hold", stall_cnt, 32'd2);
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_wb(1'b1, 5'd6, 32'd0);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);

    // x0: never busy, always reads as zero
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    bus.rf_rs1_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_id_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("x0_ex_rs1",   bus.ex_rs1_data, 32'd0);
    chk("x0_busy",     dut.busy, 32'd0);
    chk("x0_stall",    stall_cnt, 32'd2);

    // execute backpressure for 3 cycles, then same-cycle acceptance
    bus.ex_ready = 1'b0;
    drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    bus.rf_rs1_data = 32'd11;
    bus.rf_rs2_data = 32'd22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_id_ready", {31'd0, bus.id_ready}, 32'd0);
      chk("bp_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("bp_ex_rs1",   bus.ex_rs1_data, 32'd0);
      tick();
    end
    chk("bp_stall_not_counted", stall_cnt, 32'd2);
    bus.ex_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("bp_ex_rs1_new", bus.ex_rs1_data, 32'd11);
    chk("bp_ex_rs2_new", bus.ex_rs2_data, 32'd22);

    // WAW on x7: stall, then issue while write-back clears the old x7
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    chk("waw_busy7", {31'd0, dut.busy[7]}, 32'd1);
    #1;
    chk("waw_rdy0", {31'd0, bus.id_ready}, 32'd0);
    tick();
    chk("waw_stall_cnt", stall_cnt, 32'd3);
    drive_wb(1'b1, 5'd7, 32'd77);
    #1;
    chk("waw_rdy_on_wb", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("waw_set_wins", {31'd0, dut.busy[7]}, 32'd1);
    chk("waw_ex_rd",    {27'd0, bus.ex_rd_addr}, 32'd7);
    drive_wb(1'b0, 5'd0, 32'd0);

    // flush with busy x4/x9 and an instruction waiting in decode
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    chk("fl_busy49", {30'd0, dut.busy[9], dut.busy[4]}, 32'd3);
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    bus.rf_rs1_data = 32'd33;
    flush = 1'b1;
    #1;
    chk("fl_id_ready", {31'd0, bus.id_ready}, 32'd0);
    tick();
    flush = 1'b0;
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fl_busy",     dut.busy, 32'd0);
    chk("fl_ex_rd",    {27'd0, bus.ex_rd_addr}, 32'd9);
    chk("fl_stall",    stall_cnt, 32'd3);

    // asynchronous reset between clock edges
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
    tick();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("ar_pre_valid", {31'd0, bus.ex_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("ar_busy",     dut.busy, 32'd0);
    chk("ar_stall",    stall_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
